// File: rtl/ring_decoder_checker_pkg.sv
// ring_pkg: shared types and helpers for the ring decoder/checker slice.
// Provides the lock FSM state enum, a one-hot legality test, one-hot to index
// encoding and the ring successor rule (ring shifts toward LSB, bit0 wraps to MSB).
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } ring_state_e;

  // Helpers operate on a zero-extended word so they serve any WIDTH up to MAX_W.
  localparam int MAX_W = 32;
  typedef logic [MAX_W-1:0] ring_word_t;

  function automatic logic is_onehot(input ring_word_t word);
    return (word != '0) && ((word & (word - ring_word_t'(1))) == '0);
  endfunction

  function automatic int onehot_to_idx(input ring_word_t word);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (word[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int ring_succ(input int idx, input int width);
    return (idx == 0) ? width - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/ring_decoder_checker_enc.sv
// ring_onehot_enc: combinational one-hot to binary index encoder with legal flag.
// Ports: word_i (ring word), idx_o (position of set bit, meaningful only when
// legal_o), legal_o (exactly one bit set).
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             legal_o
);

  ring_word_t word_ext;

  always_comb begin
    word_ext = ring_word_t'(word_i);
    legal_o  = is_onehot(word_ext);
    idx_o    = IDX_W'(onehot_to_idx(word_ext));
  end

endmodule

// File: rtl/ring_decoder_checker.sv
// ring_decoder_checker: decodes a one-hot ring word to an index, checks legality and
// single-step rotation, tracks lock (HUNT/ACQ/LOCK) and counts errors seen in LOCK.
// Ports: clk/rst (sync, active-high), in_valid/ring_in/clr_err in; idx_out, idx_valid,
// onehot_err, step_err, locked, err_count, err_word out. All outputs registered, 1 cycle.
// Optional macro RING_ERR_CAPTURE_EN: err_word latches the first sample that was
// counted as an error while in LOCK; without it err_word is constant 0.
module ring_decoder_checker
  import ring_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     ring_in,
  input  logic                 clr_err,
  output logic [IDX_W-1:0]     idx_out,
  output logic                 idx_valid,
  output logic                 onehot_err,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     err_word
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  ring_state_e          state_q;
  logic [IDX_W-1:0]     prev_q;
  logic [GOOD_W-1:0]    good_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 idx_valid_q;
  logic                 onehot_err_q;
  logic                 step_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [ERR_CNT_W-1:0] err_count_d;

  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_legal;
  logic                 succ_ok;
  logic                 lock_err;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .word_i  (ring_in),
    .idx_o   (enc_idx),
    .legal_o (enc_legal)
  );

  always_comb begin
    succ_ok  = (int'(enc_idx) == ring_succ(int'(prev_q), WIDTH));
    // Any accepted sample in LOCK that is not the correct legal successor is counted.
    lock_err = in_valid && (state_q == LOCK) && !(enc_legal && succ_ok);
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (lock_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      good_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_count_q  <= err_count_d;
      if (in_valid) begin
        if (enc_legal) begin
          idx_q       <= enc_idx;
          idx_valid_q <= 1'b1;
        end else begin
          onehot_err_q <= 1'b1;
        end
        case (state_q)
          HUNT: begin
            if (enc_legal) begin
              state_q <= ACQ;
              prev_q  <= enc_idx;
              good_q  <= '0;
            end
          end
          ACQ: begin
            if (!enc_legal) begin
              state_q <= HUNT;
            end else if (succ_ok) begin
              prev_q <= enc_idx;
              good_q <= GOOD_W'(int'(good_q) + 1);
              if (int'(good_q) + 1 == LOCK_CNT) state_q <= LOCK;
            end else begin
              step_err_q <= 1'b1;
              prev_q     <= enc_idx;
              good_q     <= '0;
            end
          end
          LOCK: begin
            if (enc_legal && succ_ok) begin
              prev_q <= enc_idx;
            end else begin
              if (enc_legal) step_err_q <= 1'b1;
              state_q <= HUNT;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign idx_out    = idx_q;
  assign idx_valid  = idx_valid_q;
  assign onehot_err = onehot_err_q;
  assign step_err   = step_err_q;
  assign locked     = (state_q == LOCK);
  assign err_count  = err_count_q;

`ifdef RING_ERR_CAPTURE_EN
  logic [WIDTH-1:0] err_word_q;
  logic             err_cap_q;

  // Only the first counted error is kept; clr_err re-arms the capture.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_word_q <= '0;
      err_cap_q  <= 1'b0;
    end else if (lock_err && !err_cap_q) begin
      err_word_q <= ring_in;
      err_cap_q  <= 1'b1;
    end
  end

  assign err_word = err_word_q;
`else
  assign err_word = '0;
`endif

endmodule

// File: tb/tb_ring_decoder_checker.sv
module tb_ring_decoder_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] ring_in;
  logic       clr_err;
  logic [1:0] idx_out;
  logic       idx_valid;
  logic       onehot_err;
  logic       step_err;
  logic       locked;
  logic [1:0] err_count;
  logic [3:0] err_word;

  int n_cmp;
  int n_bad;

`ifdef RING_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  ring_decoder_checker #(
    .WIDTH     (4),
    .LOCK_CNT  (3),
    .ERR_CNT_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .ring_in    (ring_in),
    .clr_err    (clr_err),
    .idx_out    (idx_out),
    .idx_valid  (idx_valid),
    .onehot_err (onehot_err),
    .step_err   (step_err),
    .locked     (locked),
    .err_count  (err_count),
    .err_word   (err_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic v, input logic [3:0] w, input logic c, input logic r);
    in_valid = v;
    ring_in  = w;
    clr_err  = c;
    rst      = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ring_in  = 4'b0000;
    clr_err  = 1'b0;
    rst      = 1'b0;
  endtask

  // From HUNT: four correct steps lock the checker (last idx = 1).
  task automatic relock(input string tag);
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    drive(1'b1, 4'b1000, 1'b0, 1'b0);
    drive(1'b1, 4'b0100, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 1'b0, 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL relock_%s: locked=%b required 1", tag, locked);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    n_cmp++;
    if ({idx_out, idx_valid, onehot_err, step_err, locked, err_count, err_word} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: idx=%0d v=%b oh=%b st=%b lk=%b cnt=%0d ew=%b required all 0",
               idx_out, idx_valid, onehot_err, step_err, locked, err_count, err_word);
    end
  endtask

  task automatic test_lock_walk();
    logic [3:0] words [4];
    logic [1:0] exp_idx [4];
    logic       exp_lk [4];
    words   = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    exp_idx = '{2'd0, 2'd3, 2'd2, 2'd1};
    exp_lk  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      n_cmp++;
      if ({idx_out, idx_valid, locked, onehot_err, step_err} !== {exp_idx[i], 1'b1, exp_lk[i], 2'b00}) begin
        n_bad++;
        $display("FAIL walk_%0d: idx=%0d v=%b lk=%b oh=%b st=%b required idx=%0d v=1 lk=%b oh=0 st=0",
                 i, idx_out, idx_valid, locked, onehot_err, step_err, exp_idx[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_onehot_err();
    drive(1'b1, 4'b0110, 1'b0, 1'b0);
    n_cmp++;
    if ({onehot_err, step_err, idx_valid, idx_out, locked, err_count} !== {3'b100, 2'd1, 1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL onehot_err: oh=%b st=%b v=%b idx=%0d lk=%b cnt=%0d required oh=1 st=0 v=0 idx=1 lk=0 cnt=1",
               onehot_err, step_err, idx_valid, idx_out, locked, err_count);
    end
    n_cmp++;
    if (err_word !== (CAP ? 4'b0110 : 4'b0000)) begin
      n_bad++;
      $display("FAIL onehot_err_word: err_word=%b required %b", err_word, CAP ? 4'b0110 : 4'b0000);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if ({onehot_err, err_count} !== {1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL onehot_once: oh=%b cnt=%0d required oh=0 cnt=1", onehot_err, err_count);
    end
  endtask

  task automatic test_step_err();
    relock("pre_step");
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    n_cmp++;
    if ({locked, idx_out, step_err} !== {1'b1, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL step_ok: lk=%b idx=%0d st=%b required lk=1 idx=0 st=0", locked, idx_out, step_err);
    end
    drive(1'b1, 4'b0100, 1'b0, 1'b0);
    n_cmp++;
    if ({step_err, onehot_err, idx_valid, idx_out, locked, err_count} !== {3'b101, 2'd2, 1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL step_err: st=%b oh=%b v=%b idx=%0d lk=%b cnt=%0d required st=1 oh=0 v=1 idx=2 lk=0 cnt=2",
               step_err, onehot_err, idx_valid, idx_out, locked, err_count);
    end
    n_cmp++;
    if (err_word !== (CAP ? 4'b0110 : 4'b0000)) begin
      n_bad++;
      $display("FAIL step_err_word_hold: err_word=%b required %b", err_word, CAP ? 4'b0110 : 4'b0000);
    end
    drive(1'b1, 4'b0010, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    drive(1'b1, 4'b1000, 1'b0, 1'b0);
    n_cmp++;
    if ({locked, step_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL reacq_partial: lk=%b st=%b required lk=0 st=0", locked, step_err);
    end
    drive(1'b1, 4'b0100, 1'b0, 1'b0);
    n_cmp++;
    if ({locked, idx_out} !== {1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL reacq_lock: lk=%b idx=%0d required lk=1 idx=2", locked, idx_out);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] words [5];
    logic [1:0] exp_idx [5];
    logic       exp_lk [5];
    logic       exp_v [5];
    logic       exp_oh [5];
    words   = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0110};
    exp_idx = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd1};
    exp_lk  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_oh  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g <= i; g++) begin
        drive(1'b0, 4'b0101, 1'b0, 1'b0);
        n_cmp++;
        if ({idx_valid, onehot_err, step_err} !== 3'b000 || idx_out !== (i == 0 ? 2'd0 : exp_idx[i-1])) begin
          n_bad++;
          $display("FAIL gap_%0d_%0d: v=%b oh=%b st=%b idx=%0d required no pulses, idx held",
                   i, g, idx_valid, onehot_err, step_err, idx_out);
        end
      end
      drive(1'b1, words[i], 1'b0, 1'b0);
      n_cmp++;
      if ({idx_out, idx_valid, locked, onehot_err} !== {exp_idx[i], exp_v[i], exp_lk[i], exp_oh[i]}) begin
        n_bad++;
        $display("FAIL gapwalk_%0d: idx=%0d v=%b lk=%b oh=%b required idx=%0d v=%b lk=%b oh=%b",
                 i, idx_out, idx_valid, locked, onehot_err, exp_idx[i], exp_v[i], exp_lk[i], exp_oh[i]);
      end
    end
    n_cmp++;
    if (err_count !== 2'd1) begin
      n_bad++;
      $display("FAIL gap_errcnt: cnt=%0d required 1", err_count);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      relock("sat");
      drive(1'b1, 4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if ({err_count, onehot_err, locked} !== {exp_cnt[k], 2'b10}) begin
        n_bad++;
        $display("FAIL saturate_%0d: cnt=%0d oh=%b lk=%b required cnt=%0d oh=1 lk=0",
                 k, err_count, onehot_err, locked, exp_cnt[k]);
      end
    end
  endtask

  task automatic test_clr_err();
    relock("clr");
    drive(1'b1, 4'b0110, 1'b1, 1'b0);
    n_cmp++;
    if ({err_count, onehot_err, locked, err_word} !== {2'd0, 2'b10, 4'b0000}) begin
      n_bad++;
      $display("FAIL clr_with_err: cnt=%0d oh=%b lk=%b ew=%b required cnt=0 oh=1 lk=0 ew=0000",
               err_count, onehot_err, locked, err_word);
    end
  endtask

  task automatic test_rst_mid_lock();
    relock("rst");
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    n_cmp++;
    if ({idx_out, idx_valid, onehot_err, step_err, locked, err_count, err_word} !== 11'b0) begin
      n_bad++;
      $display("FAIL rst_mid_lock: idx=%0d v=%b oh=%b st=%b lk=%b cnt=%0d ew=%b required all 0",
               idx_out, idx_valid, onehot_err, step_err, locked, err_count, err_word);
    end
    // From ACQ at idx 3, three correct steps lock; from HUNT it would take four.
    drive(1'b1, 4'b1000, 1'b0, 1'b0);
    n_cmp++;
    if ({idx_out, idx_valid, locked} !== {2'd3, 2'b10}) begin
      n_bad++;
      $display("FAIL post_rst_first: idx=%0d v=%b lk=%b required idx=3 v=1 lk=0", idx_out, idx_valid, locked);
    end
    drive(1'b1, 4'b0100, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL post_rst_acq: lk=%b required 1", locked);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    ring_in  = 4'b0000;
    clr_err  = 1'b0;
    test_reset();
    test_lock_walk();
    test_onehot_err();
    test_step_err();
    test_gaps();
    test_saturate();
    test_clr_err();
    test_rst_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
